frame_downsampler: RTL and testbench
====================================

Name: frame_downsampler

Overview:
Upstream neighbour of the CNN inference engine. Accepts a raw grayscale camera stream of SRC_W x SRC_H 8-bit pixels and applies a 2x2 box average with rounding. Emits a (SRC_W/2) x (SRC_H/2) stream, 32x32 = 1024 pixels by default, on the engine's pixel_in / pixel_valid / frame_start interface. Frames arriving while the engine is busy are dropped whole and counted.

Parameters:
SRC_W, 64, source frame width in pixels; must be even and >= 4.
SRC_H, 64, source frame height in lines; must be even and >= 2.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cam_pixel  input  8  raw source pixel, unsigned.
cam_valid  input  1  cam_pixel valid this cycle; arbitrary gaps allowed; no backpressure.
cam_frame_start  input  1  one-cycle pulse marking start of a source frame.
cnn_busy  input  1  engine busy flag, sampled only on cam_frame_start.
pixel_out  output  8  averaged pixel to the engine's pixel_in.
pixel_valid  output  1  pixel_out valid, single-cycle strobes.
frame_start  output  1  one-cycle pulse to the engine's frame_start.
frame_done  output  1  one-cycle pulse, coincident with the last output pixel of a frame.
frame_abort  output  1  one-cycle pulse when a capturing frame is cut short.
dropped_cnt  output  8  saturating count of frames dropped due to cnn_busy.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - State IDLE; col, row, holding register and line-buffer write state cleared.
  - Line-buffer contents need no reset.
- States:
  - IDLE: ignore cam_valid.
  - CAPTURE: process pixels.
  - SKIP: discard pixels of a dropped frame.
- cam_frame_start, from any state:
  - Reset col=0, row=0.
  - If cnn_busy=1: go to SKIP, dropped_cnt += 1, saturating at 255.
  - Else: go to CAPTURE and assert frame_start on the next cycle, exactly one cycle.
  - If the state was CAPTURE and the frame was incomplete, also pulse frame_abort next cycle.
- cam_valid coincident with cam_frame_start: the pixel is pixel 0 of the new frame (processed only if the new frame is accepted).
- Counters:
  - col advances 0..SRC_W-1 on each accepted cam_valid and wraps to 0 with row+1.
  - After pixel (SRC_W-1, SRC_H-1): return to IDLE. Extra pixels are ignored until the next cam_frame_start.
  - SKIP also counts pixels and exits to IDLE at the end of its frame.
- Datapath, in CAPTURE on cam_valid:
  - Even col: h_reg <= cam_pixel.
  - Even row, odd col: line_buf[col>>1] <= h_reg + cam_pixel (9-bit).
  - Odd row, odd col:
    - sum = line_buf[col>>1] + h_reg + cam_pixel (10-bit).
    - pixel_out <= (sum + 2) >> 2, round-half-up; max 255, so no saturation is needed.
    - pixel_valid <= 1.
- line_buf: SRC_W/2 entries x 9 bits, single-port, written on even rows and read on odd rows; suitable for BRAM inference.
- Latency: pixel_valid is registered, exactly 1 cycle after the cam_valid of the odd-row/odd-col pixel.
- pixel_valid is high for one cycle per output pixel; pixel_out holds its value between strobes.
- frame_start ordering: always precedes the first pixel_valid of its frame by >= SRC_W+1 cycles, so the engine never sees frame_start and pixel_valid together for the same frame.
- frame_done asserts with pixel_valid of output pixel index (SRC_W/2)*(SRC_H/2)-1.
- cnn_busy mid-frame: ignored; once accepted, a frame is emitted completely.
- Output count per accepted, uninterrupted frame: exactly (SRC_W/2)*(SRC_H/2) strobes; no strobes in IDLE or SKIP.

Test Plan:
- Uniform frame, all pixels 100, cnn_busy=0 -> one frame_start, 1024 pixel_valid strobes all 100, frame_done on the 1024th, frame_abort never.
- Rounding, 2x2 block values (0,0,0,1) / (0,0,1,1) / (1,2,2,2) / (255,255,255,255) -> outputs 0 / 1 / 2 / 255 at the matching output index.
- Gradient frame pixel(c,r)=c*4, with random 0-5 cycle gaps in cam_valid -> output(x,y)=8x+2 for every y, independent of gaps; each strobe 1 cycle after its source pixel.
- cnn_busy=1 at cam_frame_start -> zero strobes, no frame_start, dropped_cnt=1; next frame with cnn_busy=0 -> normal 1024 outputs; 260 busy frames -> dropped_cnt=255.
- Second cam_frame_start after 2000 source pixels -> frame_abort pulse, new frame_start, then full 1024 outputs from the new frame only.
- rst_n low for 1 cycle mid-frame -> all outputs 0 immediately, IDLE, subsequent pixels ignored until the next cam_frame_start, which yields a correct full frame.

Source files
------------

// File: rtl/frame_downsampler.sv
// 2x2 box-average downsampler between the camera and the CNN engine.
// Frames that start while the engine is busy are skipped whole and counted.
module frame_downsampler #(
  parameter int unsigned SRC_W = 64,
  parameter int unsigned SRC_H = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cam_pixel,
  input  logic       cam_valid,
  input  logic       cam_frame_start,
  input  logic       cnn_busy,
  output logic [7:0] pixel_out,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_abort,
  output logic [7:0] dropped_cnt
);

  localparam int unsigned ColW = $clog2(SRC_W);
  localparam int unsigned RowW = $clog2(SRC_H);
  localparam int unsigned Half = SRC_W / 2;

  typedef enum logic [1:0] {StIdle, StCapture, StSkip} state_e;

  state_e          state_q, state_d, state_eff;
  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [RowW-1:0] row_q, row_d, row_eff;
  logic [7:0]      h_q, h_d;
  logic [7:0]      pix_q, pix_d;
  logic            pv_q, pv_d;
  logic            fs_q, fs_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [7:0]      drop_q, drop_d;

  logic [8:0]      line_buf [Half];
  logic [8:0]      lb_rd_q;
  logic            lb_we, lb_re;
  logic [ColW-2:0] lb_addr;
  logic [8:0]      lb_wdata;
  logic [9:0]      sum;
  logic            last_col, last_row;

  always_comb begin
    state_eff = state_q;
    col_eff   = col_q;
    row_eff   = row_q;
    fs_d      = 1'b0;
    abort_d   = 1'b0;
    drop_d    = drop_q;
    // A new frame start overrides whatever frame was in progress.
    if (cam_frame_start) begin
      col_eff = '0;
      row_eff = '0;
      abort_d = (state_q == StCapture);
      if (cnn_busy) begin
        state_eff = StSkip;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        state_eff = StCapture;
        fs_d      = 1'b1;
      end
    end

    state_d  = state_eff;
    col_d    = col_eff;
    row_d    = row_eff;
    h_d      = h_q;
    pix_d    = pix_q;
    pv_d     = 1'b0;
    done_d   = 1'b0;
    lb_we    = 1'b0;
    lb_re    = 1'b0;
    lb_addr  = col_eff[ColW-1:1];
    lb_wdata = {1'b0, h_q} + {1'b0, cam_pixel};
    sum      = {1'b0, lb_rd_q} + {2'b00, h_q} + {2'b00, cam_pixel};
    last_col = (col_eff == ColW'(SRC_W - 1));
    last_row = (row_eff == RowW'(SRC_H - 1));

    if (cam_valid && (state_eff != StIdle)) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = StIdle;
        end else begin
          row_d = row_eff + RowW'(1);
        end
      end else begin
        col_d = col_eff + ColW'(1);
      end

      if (state_eff == StCapture) begin
        if (!col_eff[0]) begin
          h_d   = cam_pixel;
          // Fetch the upper-line pair sum one pixel early for a registered read.
          lb_re = row_eff[0];
        end else if (!row_eff[0]) begin
          lb_we = 1'b1;
        end else begin
          pv_d   = 1'b1;
          pix_d  = 8'((sum + 10'd2) >> 2);
          done_d = last_col && last_row;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_addr] <= lb_wdata;
    if (lb_re) lb_rd_q <= line_buf[lb_addr];
  end

  assign pixel_out   = pix_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign dropped_cnt = drop_q;

endmodule

// File: tb/tb_frame_downsampler.sv
// Directed bench for frame_downsampler: scoreboard of expected strobes with
// value, arrival cycle and frame_done flag, plus frame-level pulse counts.
module tb_frame_downsampler;

  localparam int W = 64;
  localparam int H = 64;
  localparam int NOUT = (W / 2) * (H / 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cam_pixel;
  logic       cam_valid;
  logic       cam_frame_start;
  logic       cnn_busy;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       frame_start;
  logic       frame_done;
  logic       frame_abort;
  logic [7:0] dropped_cnt;

  frame_downsampler #(.SRC_W(W), .SRC_H(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cam_pixel       (cam_pixel),
    .cam_valid       (cam_valid),
    .cam_frame_start (cam_frame_start),
    .cnn_busy        (cnn_busy),
    .pixel_out       (pixel_out),
    .pixel_valid     (pixel_valid),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .frame_abort     (frame_abort),
    .dropped_cnt     (dropped_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] v;
    int         c;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] out_log[$];
  logic [7:0] img [H][W];
  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt = 0, ab_cnt = 0, done_cnt = 0;
  int b_out, b_fs, b_ab, b_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (frame_abort) ab_cnt++;
      if (frame_done) done_cnt++;
      if (pixel_valid) begin
        out_log.push_back(pixel_out);
        chk("strobe_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pixel_value", pixel_out, e.v);
          chk("pixel_cycle", cyc, e.c);
          chk("frame_done_flag", frame_done, e.done);
        end
      end
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'd100;
          2:       img[r][c] = 8'(c * 4);
          3:       img[r][c] = 8'($urandom_range(255, 0));
          default: img[r][c] = 8'd0;
        endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cam_valid       = 1'b0;
    cam_frame_start = 1'b0;
    cnn_busy        = 1'b0;
  endtask

  // Drives one source pixel; accepted frames queue the model's expectation.
  task automatic drive_px(input int c, input int r, input bit acc);
    int   s;
    exp_t e;
    cam_valid = 1'b1;
    cam_pixel = img[r][c];
    if (acc && (c % 2 == 1) && (r % 2 == 1)) begin
      s = img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c];
      e.v    = 8'((s + 2) / 4);
      e.c    = cyc + 1;
      e.done = (c == W - 1) && (r == H - 1);
      sb.push_back(e);
    end
    step();
  endtask

  task automatic run_frame(input bit busy, input int npix, input int maxgap, input bit coinc);
    int i0;
    cam_frame_start = 1'b1;
    cnn_busy        = busy;
    if (coinc) drive_px(0, 0, !busy);
    else step();
    i0 = coinc ? 1 : 0;
    for (int i = i0; i < npix; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) step();
      drive_px(i % W, i / W, !busy);
    end
  endtask

  task automatic snap();
    b_out  = out_log.size();
    b_fs   = fs_cnt;
    b_ab   = ab_cnt;
    b_done = done_cnt;
  endtask

  task automatic frame_checks(input string tag, input int e_out, input int e_fs,
                              input int e_ab, input int e_done);
    repeat (4) step();
    chk({tag, "_outputs"}, out_log.size() - b_out, e_out);
    chk({tag, "_frame_start"}, fs_cnt - b_fs, e_fs);
    chk({tag, "_frame_abort"}, ab_cnt - b_ab, e_ab);
    chk({tag, "_frame_done"}, done_cnt - b_done, e_done);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    cam_pixel       = 8'd0;
    cam_valid       = 1'b0;
    cam_frame_start = 1'b0;
    cnn_busy        = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_abort", frame_abort, 0);
    chk("rst_dropped", dropped_cnt, 0);
    rst_n = 1'b1;
    step();

    // Uniform frame, pixel 0 coincident with the frame start.
    fill(0);
    snap();
    run_frame(0, W * H, 0, 1);
    frame_checks("uniform", NOUT, 1, 0, 1);
    for (int i = 0; i < NOUT; i += 97) chk("uniform_val", out_log[b_out + i], 100);

    // Rounding blocks at output indices 0..3.
    fill(1);
    img[0][0] = 0;   img[0][1] = 0;   img[1][0] = 0;   img[1][1] = 1;
    img[0][2] = 0;   img[0][3] = 0;   img[1][2] = 1;   img[1][3] = 1;
    img[0][4] = 1;   img[0][5] = 2;   img[1][4] = 2;   img[1][5] = 2;
    img[0][6] = 255; img[0][7] = 255; img[1][6] = 255; img[1][7] = 255;
    snap();
    run_frame(0, W * H, 0, 0);
    frame_checks("round", NOUT, 1, 0, 1);
    chk("round_0", out_log[b_out + 0], 0);
    chk("round_1", out_log[b_out + 1], 1);
    chk("round_2", out_log[b_out + 2], 2);
    chk("round_255", out_log[b_out + 3], 255);

    // Gradient with random valid gaps.
    fill(2);
    snap();
    run_frame(0, W * H, 5, 0);
    frame_checks("grad", NOUT, 1, 0, 1);
    for (int i = 0; i < NOUT; i += 13) chk("grad_val", out_log[b_out + i], 8 * (i % 32) + 2);

    // Busy frame is skipped, the next one is processed.
    fill(3);
    snap();
    run_frame(1, W * H, 0, 0);
    frame_checks("busy", 0, 0, 0, 0);
    chk("dropped_one", dropped_cnt, 1);
    snap();
    run_frame(0, W * H, 0, 0);
    frame_checks("after_busy", NOUT, 1, 0, 1);
    for (int i = 0; i < 260; i++) begin
      cam_frame_start = 1'b1;
      cnn_busy        = 1'b1;
      step();
    end
    step();
    chk("dropped_sat", dropped_cnt, 255);

    // Restart mid-frame after 2000 pixels.
    fill(0);
    snap();
    run_frame(0, 2000, 0, 0);
    repeat (3) step();
    chk("partial_outputs", out_log.size() - b_out, 488);
    fill(3);
    snap();
    run_frame(0, W * H, 0, 0);
    frame_checks("restart", NOUT, 1, 1, 1);

    // Asynchronous reset mid-frame.
    fill(2);
    run_frame(0, 500, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pixel_valid", pixel_valid, 0);
    chk("arst_pixel_out", pixel_out, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_dropped", dropped_cnt, 0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    snap();
    for (int i = 0; i < 300; i++) drive_px(i % W, i / W, 0);
    frame_checks("post_rst_idle", 0, 0, 0, 0);
    fill(3);
    snap();
    run_frame(0, W * H, 2, 0);
    frame_checks("post_rst", NOUT, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
